// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx and uart_tx: receiver state
// encoding, data width and the default bit period.
package uart_pkg;

  // Bits per character and the width of the bit index that walks them.
  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(DATA_W);

  // Default clocks per serial bit; uart_tx and uart_rx must agree on it.
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  // Receiver states. PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for bringing an asynchronous
// level into the clk domain. RESET_VAL sets the value both flops take
// under reset so the output looks like the signal's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is safe to use downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers 8-bit frames (start, 8 data LSB first, optional
// even parity, stop) from an asynchronous serial line and presents each good
// byte on data with a one-cycle done strobe.
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after
// the data bits and enable parity_err; otherwise frames are 8N1 and
// parity_err is tied low.
//
// The byte output is named data because do is a reserved word.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  // The mid-start alignment needs an even period of at least four clocks.
  if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_bad_cfg
    $error("uart_rx: CLKS_PER_BIT must be even and at least 4");
  end

  // Synchronized serial line; idles high so reset looks like an idle line.
  logic rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (rx_s)
  );

  rx_state_e         state,       state_n;
  logic [CNT_W-1:0]  cnt,         cnt_n;
  logic [IDX_W-1:0]  idx,         idx_n;
  logic [DATA_W-1:0] shreg,       shreg_n;
  logic [DATA_W-1:0] data_n;
  logic              done_n;
  logic              frame_err_n;
`ifdef UART_RX_PARITY_EN
  logic              par,          par_n;
  logic              parity_err_q, parity_err_n;
`endif

  // Next-state, counter, shift-register and pulse logic.
  // NOTE: every signal gets a default first so no path can infer a latch;
  // combinational blocks use blocking (=) assignments only.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    data_n      = data;
    done_n      = 1'b0;
    frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n        = par;
    parity_err_n = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = ST_START;
        end
      end

      // Wait to the middle of the start bit and confirm it is still low.
      ST_START: begin
        if (cnt == CNT_MID) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // From here on cnt wraps once per bit, landing on mid-bit each time.
      ST_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n          = '0;
          shreg_n[idx]   = rx_s;
          if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = ST_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif

      // Judge the frame at mid-stop; a low stop bit outranks bad parity.
      // Leaving here at mid-bit tolerates a transmitter up to half a bit fast.
      ST_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            frame_err_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shreg, par}) begin
            parity_err_n = 1'b1;
`endif
          end else begin
            data_n = shreg;
            done_n = 1'b1;
          end
          state_n = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // Line held low (break): wait quietly for it to return high.
      ST_WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  // NOTE: clocked state uses non-blocking (<=) assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par          <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      done      <= done_n;
      frame_err <= frame_err_n;
`ifdef UART_RX_PARITY_EN
      par          <= par_n;
      parity_err_q <= parity_err_n;
`endif
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, the receive-side counterpart of `uart_tx`. It recovers 8N1 frames from a single asynchronous serial line using the same bit period as `uart_tx`, and presents each byte on a parallel output with a one-cycle `done` strobe. It sits between the board RX pin and byte-level consumers, and runs in loopback against `uart_tx` in system benches.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per serial bit. Must be even, ≥ 4, and equal to the `uart_tx` setting.
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in`  in  1: serial line. Idles high. Asynchronous to `clk`.
- `do`  out  8: last good byte, LSB received first. Holds until the next good frame.
- `done`  out  1: one-cycle pulse when `do` is updated.
- `busy`  out  1: high from start-bit detection until return to IDLE.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1: one-cycle pulse on parity mismatch. Tied 0 when parity is not compiled in.

## Operation
- `in` passes through a 2-flop synchronizer, giving `rx_s`. Flops reset to 1. All decisions use `rx_s`.
- Bit counter `cnt` counts 0..CLKS_PER_BIT-1. Bit index `idx` counts 0..7.
- States:
  - IDLE: on `rx_s`=0, go to START with `cnt`=0.
  - START: when `cnt`=CLKS_PER_BIT/2-1, sample `rx_s`. If 1, it is a glitch: return to IDLE with no pulse. If 0, go to DATA with `cnt`=0 and `idx`=0.
  - DATA: when `cnt`=CLKS_PER_BIT-1 (mid-bit), shift `rx_s` into `shreg[idx]`. After `idx`=7, go to PARITY if it is compiled in, otherwise to STOP.
  - PARITY: mid-bit, sample the parity bit and go to STOP.
  - STOP: mid-bit, sample `rx_s`.
    - If 1 and parity is OK (or not compiled in): load `do`<=`shreg` and pulse `done`.
    - If 1 and parity mismatches: pulse `parity_err`. `do` is unchanged.
    - If 0: pulse `frame_err`. `do` is unchanged; `frame_err` takes precedence over `parity_err`.
    - Then go to IDLE if `rx_s`=1, else to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This handles a break (line held low) and produces no repeated errors.
- `busy` = (state ≠ IDLE).
- The receiver returns to IDLE at mid-stop-bit, which tolerates a transmitter that is up to half a bit fast. Back-to-back frames from `uart_tx` must be received with no loss.

## Timing
- Reset values: `do`=8'h00, `done`=0, `busy`=0, `frame_err`=0, `parity_err`=0, state=IDLE, synchronizer=1.
- Reset mid-frame abandons the frame immediately. No pulse is issued after reset is released.
- Latency: the `done`/`frame_err`/`parity_err` pulse is registered. It is high in the cycle beginning 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT clock edges after the first edge that samples `in`=0. Add CLKS_PER_BIT when parity is compiled in.
- `do` changes only on the same edge that raises `done`.
- Pulses last exactly one cycle. No consumer handshake exists; the consumer must capture `do` on `done` or before the next frame completes.
- Low glitches on `in` shorter than CLKS_PER_BIT/2 - 1 cycles are rejected.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is start, 8 data bits, an even-parity bit, then stop. Parity is even: the XOR of the data bits and the parity bit must be 0. PARITY state and `parity_err` are live.
- `UART_RX_PARITY_EN` undefined: 8N1 frame. PARITY state is absent and `parity_err` is held at 0.
- `uart_tx` must be built with the matching setting.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding typedef (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - the data width constant (8);
  - the default CLKS_PER_BIT, shared with `uart_tx`.
- One sub-module, `sync_2ff`: a generic 2-flop synchronizer with a reset value parameter. It is reusable elsewhere.
- The rest is a single FSM, counters, and shift register in `uart_rx`.

## Test plan
- Loopback `uart_tx` → `uart_rx`, send 8'h33 then 8'hE3 → `done` pulses twice; `do`=8'h33, then 8'hE3. Latency matches the Timing formula exactly.
- Back-to-back: `uart_tx` restarted the cycle after its `done`, bytes 8'h00, 8'hFF, 8'hA5 → three `done` pulses, correct data, `frame_err` never asserts.
- Glitch: drive `in` low for 3 cycles (CLKS_PER_BIT=16) → no pulse, `busy` returns to 0, and a subsequent 8'h5A frame is received correctly.
- Framing error: 8'h3C frame with the stop bit driven low, line held low 3 bit times → one `frame_err` pulse, `do` keeps its prior value, no `done`. The next frame is received after the line returns high.
- Reset mid-frame: assert `rst` during data bit 4 of 8'h96 → all outputs return to reset values in the same cycle, no pulse follows, and the next 8'h69 frame is received correctly.
- With `UART_RX_PARITY_EN`: 8'h07 sent with parity 1 → `done`, `do`=8'h07. Same frame with parity 0 → `parity_err` pulse, `do` unchanged.
